// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and per-boundary payload types for pipeline stage registers
package pipe_pkg;
    localparam logic [31:0] BUBBLE_PC = 32'h1bff_fffc;
    localparam logic [31:0] RESET_PC  = 32'h1c00_0000;

    typedef struct packed {
        logic [31:0] inst;
    } if_id_payload_t;

    typedef struct packed {
        logic [11:0] alu_op;
        logic [31:0] alu_src1;
        logic [31:0] alu_src2;
        logic [31:0] rkd_value;
        logic        mem_en;
        logic [3:0]  data_sram_we;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        rf_or_mem;
    } id_exe_payload_t;

    typedef struct packed {
        logic        mem_en;
        logic [3:0]  data_sram_we;
        logic [31:0] rkd_value;
        logic [31:0] alu_result;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        rf_or_mem;
        logic        br_taken;
        logic [31:0] br_target;
    } exe_mem_payload_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_wb_payload_t;

    localparam int IF_ID_W   = $bits(if_id_payload_t);
    localparam int ID_EXE_W  = $bits(id_exe_payload_t);
    localparam int EXE_MEM_W = $bits(exe_mem_payload_t);
    localparam int MEM_WB_W  = $bits(mem_wb_payload_t);

    function automatic logic is_bubble(input logic [31:0] pc, input logic [31:0] bubble_pc);
        return pc == bubble_pc;
    endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+pc+payload register; load wins over clear, payload only moves on load
module pipe_slot #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [31:0]       d_pc,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [31:0]       pc,
    output logic [DATA_W-1:0] data
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            data  <= '0;
        end else begin
            valid <= load | (valid & ~clear);
            if (load) begin
                pc   <= d_pc;
                data <= d_data;
            end
        end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready inter-stage register with flush, bubble drop and optional skid slot
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          DATA_W      = 64,
    parameter int          SKID        = 0,
    parameter int          DROP_BUBBLE = 1,
    parameter logic [31:0] BUBBLE_PC   = pipe_pkg::BUBBLE_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_data
);
    logic acc, st, pop;

    assign pop = out_valid & out_ready;
    assign acc = in_valid & in_ready & ~flush;
    assign st  = acc & ~((DROP_BUBBLE != 0) & is_bubble(in_pc, BUBBLE_PC));

    generate
        if (SKID == 0) begin : g_single
            assign in_ready = ~out_valid | out_ready;
            pipe_slot #(.DATA_W(DATA_W)) u_head (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (st),
                .clear  (flush | pop),
                .d_pc   (in_pc),
                .d_data (in_data),
                .valid  (out_valid),
                .pc     (out_pc),
                .data   (out_data)
            );
        end else begin : g_skid
            logic              s_valid, h_load, s_load;
            logic [31:0]       s_pc;
            logic [DATA_W-1:0] s_data;
            // S only fills when H is stuck, so in_ready never depends on out_ready
            assign in_ready = ~s_valid;
            assign h_load   = ~flush & ((pop & s_valid) | (st & (~out_valid | pop)));
            assign s_load   = st & out_valid & ~pop;
            pipe_slot #(.DATA_W(DATA_W)) u_head (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (h_load),
                .clear  (flush | pop),
                .d_pc   (s_valid ? s_pc : in_pc),
                .d_data (s_valid ? s_data : in_data),
                .valid  (out_valid),
                .pc     (out_pc),
                .data   (out_data)
            );
            pipe_slot #(.DATA_W(DATA_W)) u_skid (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (s_load),
                .clear  (flush | pop),
                .d_pc   (in_pc),
                .d_data (in_data),
                .valid  (s_valid),
                .pc     (s_pc),
                .data   (s_data)
            );
        end
    endgenerate
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic inter-stage pipeline register that replaces hand-written stage latches such as the EXE→MEM latch, parametrised in payload width and buffering depth. It adds a valid/ready handshake, flush, and configurable bubble filtering on a reserved PC. It sits between any two core stages (IF/ID/EXE/MEM/WB). The upstream stage presents a PC plus an opaque payload; the downstream stage consumes them.

Parameters:
DATA_W, 64, width of opaque payload (control + data fields packed by the instantiating stage)
SKID, 0, 0 = single slot with combinational ready; 1 = two-slot skid buffer with registered in_ready
DROP_BUBBLE, 1, 1 = a handshaken beat with in_pc == BUBBLE_PC is consumed but not stored
BUBBLE_PC, 32'h1bfffffc, reserved PC marking the pre-reset fetch bubble

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill everything held and anything offered this cycle
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept (the "allowin" signal)
in_pc  in  32  upstream PC
in_data  in  DATA_W  upstream payload
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream accepts
out_pc  out  32  PC of head beat
out_data  out  DATA_W  payload of head beat

Behaviour:
- Reset (rst_n low, asynchronous): all valid bits 0; out_pc = 0; out_data = 0; skid slot pc/data = 0. in_ready = 1 while reset is held. Reset in mid-operation discards all held beats immediately.
- Accept condition: acc = in_valid & in_ready & ~flush.
- Store condition: st = acc & ~(DROP_BUBBLE & in_pc == BUBBLE_PC). A dropped bubble completes the handshake but leaves no trace.
- Pop condition: pop = out_valid & out_ready.
- Payload registers load only when written; otherwise they hold. Valid bits alone define occupancy.
- flush has priority: at the next edge all valid bits = 0; no store happens that cycle; out_data/out_pc hold stale values.
- SKID=0 (one slot, latency 1):
  - in_ready = ~out_valid | out_ready (combinational from out_ready).
  - On st the slot loads and out_valid=1.
  - On pop without st, out_valid=0.
  - On pop with st, the slot reloads and out_valid stays 1. Full throughput: 1 beat/cycle.
- SKID=1 (two slots: head H, skid S; latency 1):
  - in_ready = ~S.valid, a pure register output with no combinational path from out_ready.
  - Empty + st: H loads.
  - H valid, no pop, st: S loads.
  - H valid, pop, st, S empty: H loads from input.
  - pop with S valid: H ← S; S loads input if st, else S.valid=0.
  - Order is always preserved (H older than S).
  - Full throughput with out_ready high. Holds 2 beats under backpressure.
- out_valid = H.valid; out_pc/out_data = H contents.
- Simultaneous flush + pop: the pop is honoured downstream; the stage is still empty next cycle.
- No combinational path from in_* to out_* in either mode.

Decomposition:
- Package pipe_pkg: BUBBLE_PC and RESET_PC constants, plus the per-boundary packed payload typedefs (e.g. exe_mem_payload_t: mem_en, data_sram_we[3:0], rkd_value, alu_result, rf_we, rf_waddr, rf_or_mem, br_taken, br_target). Also localparams giving their widths, for DATA_W.
- Sub-module pipe_slot: one valid+pc+data register with load/clear controls. Instantiated once (SKID=0) or twice (SKID=1) via generate.

Test Plan:
- Reset mid-stream: hold 2 beats (SKID=1), pulse rst_n low between edges → out_valid=0, out_pc=0, out_data=0, in_ready=1 immediately, asynchronously.
- Streaming: out_ready=1, in_pc=0x1c000000,0x1c000004,0x1c000008 back-to-back → out_pc shows the same sequence one cycle later, no gaps, both SKID values.
- Backpressure SKID=1: out_ready=0, push 0x1c000000 then 0x1c000004 → in_ready=0 after the second beat. Raise out_ready → 0x1c000000 then 0x1c000004 in order, in_ready=1 one cycle after the first pop.
- Bubble: in_valid=1, in_pc=0x1bfffffc, DROP_BUBBLE=1 → in_ready stays 1, out_valid stays 0. Same with DROP_BUBBLE=0 → out_valid=1, out_pc=0x1bfffffc.
- Flush: stage full with 0x1c000010, flush=1 with in_valid=1, in_pc=0x1c000014 → next cycle out_valid=0, beat 0x1c000014 never appears.
- SKID=0 ready path: out_valid=1, toggle out_ready 0→1 within a cycle → in_ready follows combinationally. A pop plus a store in the same cycle yields the new payload with out_valid held at 1.
